// File: rtl/cga_pkg.sv
// Shared types, constants and the 5153 default-palette generator for the CGA palette mapper.
package cga_pkg;

    typedef struct packed {
        logic i;
        logic r;
        logic g;
        logic b;
    } rgbi_t;

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } load_state_t;

    localparam logic [3:0] IDX_BROWN = 4'd6;
    localparam int         PAL_DEPTH = 16;
    localparam int         CH_W_MAX  = 8;

    // Each channel is {c,i} repeated from the MSB down; odd widths simply lose the last i bit.
    function automatic logic [3*CH_W_MAX-1:0] cga_default(
        input logic [3:0] idx,
        input int         ch_w,
        input logic       brown_fix
    );
        rgbi_t      px;
        logic [1:0] v_r;
        logic [1:0] v_g;
        logic [1:0] v_b;
        logic [7:0] c_r;
        logic [7:0] c_g;
        logic [7:0] c_b;
        px  = rgbi_t'(idx);
        v_r = {px.r, px.i};
        v_g = {px.g, px.i};
        v_b = {px.b, px.i};
        if (brown_fix && (idx == IDX_BROWN)) begin
            v_g = 2'b01;
        end
        c_r = '0;
        c_g = '0;
        c_b = '0;
        for (int j = 0; j < CH_W_MAX; j++) begin
            if (j < ch_w) begin
                c_r = {c_r[6:0], v_r[~j[0]]};
                c_g = {c_g[6:0], v_g[~j[0]]};
                c_b = {c_b[6:0], v_b[~j[0]]};
            end
        end
        return ({16'd0, c_r} << (2 * ch_w)) | ({16'd0, c_g} << ch_w) | {16'd0, c_b};
    endfunction

endpackage

// File: rtl/cga_pal_regfile.sv
// 16-entry palette storage with one write port and registered read port(s).
// Optional second read port when CGA_PAL_READBACK_EN is defined.
module cga_pal_regfile
    import cga_pkg::*;
#(
    parameter int CH_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [3:0]        waddr,
    input  logic [3*CH_W-1:0] wdata,
    input  logic [3:0]        raddr,
    input  logic              rd_clr,
    output logic [3*CH_W-1:0] rdata
`ifdef CGA_PAL_READBACK_EN
    ,
    input  logic [3:0]        rd2_addr,
    output logic [3*CH_W-1:0] rd2_data
`endif
);

    logic [3*CH_W-1:0] r_mem [PAL_DEPTH];
    logic [3*CH_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Reads sample the array before this edge's write lands, so a same-index collision sees old data.
    always_ff @(posedge clk) begin
        if (rst || rd_clr) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

`ifdef CGA_PAL_READBACK_EN
    logic [3*CH_W-1:0] r_rd2_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd2_data <= '0;
        end else begin
            r_rd2_data <= r_mem[rd2_addr];
        end
    end

    assign rd2_data = r_rd2_data;
`endif

endmodule

// File: rtl/cga_palette_mapper.sv
// RGBI-to-RGB palette stage: 2-cycle pixel pipeline, default-load FSM, host write port.
// Defining CGA_PAL_READBACK_EN adds the rd_addr/rd_data palette readback port.
//
// state | meaning
// IDLE  | palette live, host writes accepted
// LOAD  | writing default entry load_ptr each cycle, outputs blanked
module cga_palette_mapper
    import cga_pkg::*;
#(
    parameter int CH_W      = 2,
    parameter int BROWN_FIX = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic [3:0]        pix_rgbi,
    input  logic              blank_in,
    input  logic              hs_in,
    input  logic              vs_in,
    output logic [CH_W-1:0]   r_out,
    output logic [CH_W-1:0]   g_out,
    output logic [CH_W-1:0]   b_out,
    output logic              out_valid,
    output logic              hs_out,
    output logic              vs_out,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [3:0]        wr_addr,
    input  logic [3*CH_W-1:0] wr_data,
    input  logic              pal_reload,
    output logic              busy
`ifdef CGA_PAL_READBACK_EN
    ,
    input  logic [3:0]        rd_addr,
    output logic [3*CH_W-1:0] rd_data
`endif
);

    localparam logic [3:0] LAST_PTR = 4'(PAL_DEPTH - 1);

    load_state_t r_state;
    load_state_t w_state_nxt;
    logic [3:0]  r_load_ptr;
    logic [3:0]  w_ptr_nxt;

    rgbi_t r_s1_idx;
    logic  r_s1_valid;
    logic  r_s1_blank;
    logic  r_s1_hs;
    logic  r_s1_vs;
    logic  r_s2_valid;
    logic  r_s2_hs;
    logic  r_s2_vs;

    logic              w_we;
    logic [3:0]        w_waddr;
    logic [3*CH_W-1:0] w_wdata;
    logic [3*CH_W-1:0] w_def;
    logic [3*CH_W-1:0] w_rd;
    logic              w_rd_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LOAD;
            r_load_ptr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_load_ptr <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_load_ptr;
        case (r_state)
            IDLE: begin
                if (pal_reload) begin
                    w_state_nxt = LOAD;
                    w_ptr_nxt   = '0;
                end
            end
            LOAD: begin
                if (pal_reload) begin
                    w_ptr_nxt = '0;
                end else begin
                    w_ptr_nxt = r_load_ptr + 4'd1;
                    if (r_load_ptr == LAST_PTR) begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = LOAD;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    assign busy     = (r_state == LOAD);
    assign wr_ready = (r_state == IDLE);

    assign w_def   = (3*CH_W)'(cga_default(r_load_ptr, CH_W, (BROWN_FIX != 0)));
    assign w_we    = busy | (wr_valid & wr_ready);
    assign w_waddr = busy ? r_load_ptr : wr_addr;
    assign w_wdata = busy ? w_def : wr_data;

    // Blanking keys off the next state so the colour outputs drop in the same cycle busy rises.
    assign w_rd_clr = r_s1_blank | (w_state_nxt == LOAD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_idx   <= '0;
            r_s1_valid <= 1'b0;
            r_s1_blank <= 1'b0;
            r_s1_hs    <= 1'b0;
            r_s1_vs    <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_hs    <= 1'b0;
            r_s2_vs    <= 1'b0;
        end else begin
            r_s1_idx   <= rgbi_t'(pix_rgbi);
            r_s1_valid <= pix_valid;
            r_s1_blank <= blank_in;
            r_s1_hs    <= hs_in;
            r_s1_vs    <= vs_in;
            r_s2_valid <= r_s1_valid;
            r_s2_hs    <= r_s1_hs;
            r_s2_vs    <= r_s1_vs;
        end
    end

    cga_pal_regfile #(
        .CH_W (CH_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .we       (w_we),
        .waddr    (w_waddr),
        .wdata    (w_wdata),
        .raddr    (r_s1_idx),
        .rd_clr   (w_rd_clr),
        .rdata    (w_rd)
`ifdef CGA_PAL_READBACK_EN
        ,
        .rd2_addr (rd_addr),
        .rd2_data (rd_data)
`endif
    );

    assign r_out     = w_rd[3*CH_W-1:2*CH_W];
    assign g_out     = w_rd[2*CH_W-1:CH_W];
    assign b_out     = w_rd[CH_W-1:0];
    assign out_valid = r_s2_valid;
    assign hs_out    = r_s2_hs;
    assign vs_out    = r_s2_vs;

endmodule

// File: tb/tb_cga_palette_mapper.sv
// Directed bench for cga_palette_mapper: a CH_W=2 and a CH_W=8 instance driven in lockstep.
module tb_cga_palette_mapper;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [3:0]  pix_rgbi;
    logic        blank_in;
    logic        hs_in;
    logic        vs_in;
    logic        wr_valid;
    logic [3:0]  wr_addr;
    logic [5:0]  wr_data2;
    logic [23:0] wr_data8;
    logic        pal_reload;

    logic [1:0]  r2, g2, b2;
    logic        ov2, hs2, vs2, wr_ready2, busy2;
    logic [7:0]  r8, g8, b8;
    logic        ov8, hs8, vs8, wr_ready8, busy8;
`ifdef CGA_PAL_READBACK_EN
    logic [3:0]  rd_addr;
    logic [5:0]  rd_data2;
    logic [23:0] rd_data8;
`endif

    int vec = 0;
    int err = 0;

    // Hand-built {r,g,b} table at CH_W=2, each channel {c,i}; entry 6 green is brown (01).
    logic [5:0] exp2 [16] = '{
        6'b00_00_00, 6'b00_00_10, 6'b00_10_00, 6'b00_10_10,
        6'b10_00_00, 6'b10_00_10, 6'b10_01_00, 6'b10_10_10,
        6'b01_01_01, 6'b01_01_11, 6'b01_11_01, 6'b01_11_11,
        6'b11_01_01, 6'b11_01_11, 6'b11_11_01, 6'b11_11_11
    };

    always #5 clk = ~clk;

    cga_palette_mapper #(.CH_W(2), .BROWN_FIX(1)) dut2 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_rgbi(pix_rgbi),
        .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in),
        .r_out(r2), .g_out(g2), .b_out(b2), .out_valid(ov2), .hs_out(hs2), .vs_out(vs2),
        .wr_valid(wr_valid), .wr_ready(wr_ready2), .wr_addr(wr_addr), .wr_data(wr_data2),
        .pal_reload(pal_reload), .busy(busy2)
`ifdef CGA_PAL_READBACK_EN
        , .rd_addr(rd_addr), .rd_data(rd_data2)
`endif
    );

    cga_palette_mapper #(.CH_W(8), .BROWN_FIX(1)) dut8 (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_rgbi(pix_rgbi),
        .blank_in(blank_in), .hs_in(hs_in), .vs_in(vs_in),
        .r_out(r8), .g_out(g8), .b_out(b8), .out_valid(ov8), .hs_out(hs8), .vs_out(vs8),
        .wr_valid(wr_valid), .wr_ready(wr_ready8), .wr_addr(wr_addr), .wr_data(wr_data8),
        .pal_reload(pal_reload), .busy(busy8)
`ifdef CGA_PAL_READBACK_EN
        , .rd_addr(rd_addr), .rd_data(rd_data8)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        tick();
        tick();
        vec++; if ({r8, g8, b8} !== 24'h0) begin err++; $display("FAIL reset_rgb8 got %h want 000000", {r8, g8, b8}); end
        vec++; if ({r2, g2, b2} !== 6'h0) begin err++; $display("FAIL reset_rgb2 got %b want 000000", {r2, g2, b2}); end
        vec++; if ({ov8, hs8, vs8} !== 3'b000) begin err++; $display("FAIL reset_ov_hs_vs got %b want 000", {ov8, hs8, vs8}); end
        vec++; if ({busy8, wr_ready8, busy2, wr_ready2} !== 4'b1010) begin err++; $display("FAIL reset_busy_ready got %b want 1010", {busy8, wr_ready8, busy2, wr_ready2}); end
`ifdef CGA_PAL_READBACK_EN
        vec++; if (rd_data8 !== 24'h0) begin err++; $display("FAIL reset_rd_data got %h want 000000", rd_data8); end
`endif
        rst = 1'b0;
        n = 0;
        while (busy8 && n < 40) begin
            tick();
            n++;
        end
        vec++; if (n !== 16) begin err++; $display("FAIL reset_load_len got %0d want 16", n); end
        vec++; if ({busy2, wr_ready8} !== 2'b01) begin err++; $display("FAIL post_load_idle got %b want 01", {busy2, wr_ready8}); end
    endtask

    task automatic test_sweep;
        pix_valid = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) pix_rgbi = 4'(k);
            tick();
            if (k == 0) begin
                vec++; if (ov2 !== 1'b0) begin err++; $display("FAIL sweep_latency ov got %b want 0", ov2); end
            end else begin
                vec++;
                if ({r2, g2, b2} !== exp2[k-1] || ov2 !== 1'b1) begin
                    err++; $display("FAIL sweep_idx%0d got %b/%b want %b/1", k-1, {r2, g2, b2}, ov2, exp2[k-1]);
                end
            end
        end
    endtask

    task automatic test_ch8;
        pix_rgbi = 4'd6;  tick();
        pix_rgbi = 4'd15; tick();
        vec++; if ({r8, g8, b8} !== 24'hAA5500) begin err++; $display("FAIL ch8_idx6 got %h want aa5500", {r8, g8, b8}); end
        pix_rgbi = 4'd8;  tick();
        vec++; if ({r8, g8, b8} !== 24'hFFFFFF) begin err++; $display("FAIL ch8_idx15 got %h want ffffff", {r8, g8, b8}); end
        tick();
        vec++; if ({r8, g8, b8} !== 24'h555555) begin err++; $display("FAIL ch8_idx8 got %h want 555555", {r8, g8, b8}); end
    endtask

    task automatic test_collision;
        pix_rgbi = 4'd1;
        tick();
        tick();
        vec++; if ({r8, g8, b8} !== 24'h0000AA) begin err++; $display("FAIL coll_pre got %h want 0000aa", {r8, g8, b8}); end
        vec++; if (wr_ready8 !== 1'b1) begin err++; $display("FAIL coll_ready got %b want 1", wr_ready8); end
        wr_valid = 1'b1;
        wr_addr  = 4'd1;
        wr_data8 = 24'h123456;
        wr_data2 = 6'b11_01_10;
        tick();
        wr_valid = 1'b0;
        vec++; if ({r8, g8, b8} !== 24'h0000AA) begin err++; $display("FAIL coll_same_cycle got %h want 0000aa", {r8, g8, b8}); end
        tick();
        vec++; if ({r8, g8, b8} !== 24'h123456) begin err++; $display("FAIL coll_next8 got %h want 123456", {r8, g8, b8}); end
        vec++; if ({r2, g2, b2} !== 6'b11_01_10) begin err++; $display("FAIL coll_next2 got %b want 110110", {r2, g2, b2}); end
        tick();
        vec++; if ({r8, g8, b8} !== 24'h123456) begin err++; $display("FAIL coll_hold got %h want 123456", {r8, g8, b8}); end
    endtask

    task automatic test_reload;
        int n;
        pal_reload = 1'b1;
        tick();
        pal_reload = 1'b0;
        vec++; if ({busy8, wr_ready8, ov8} !== 3'b101) begin err++; $display("FAIL reload_start got %b want 101", {busy8, wr_ready8, ov8}); end
        vec++; if ({r8, g8, b8} !== 24'h0) begin err++; $display("FAIL reload_blank0 got %h want 000000", {r8, g8, b8}); end
        n = 0;
        while (busy8 && n < 40) begin
            if (n == 5) begin
                wr_valid = 1'b1;
                wr_addr  = 4'd1;
                wr_data8 = 24'hFFFFFF;
                wr_data2 = 6'b111111;
            end
            tick();
            wr_valid = 1'b0;
            n++;
            if (busy8) begin
                vec++;
                if ({r8, g8, b8} !== 24'h0 || wr_ready8 !== 1'b0) begin
                    err++; $display("FAIL reload_busy_c%0d got %h/%b want 000000/0", n, {r8, g8, b8}, wr_ready8);
                end
            end
        end
        vec++; if (n !== 16) begin err++; $display("FAIL reload_len got %0d want 16", n); end
        vec++; if ({r8, g8, b8} !== 24'h0000AA) begin err++; $display("FAIL reload_idx1 got %h want 0000aa", {r8, g8, b8}); end
        tick();
        vec++; if ({r2, g2, b2} !== 6'b00_00_10) begin err++; $display("FAIL reload_idx1_ch2 got %b want 000010", {r2, g2, b2}); end
    endtask

    task automatic test_blank_sync;
        pix_rgbi = 4'd15;
        blank_in = 1'b1;
        hs_in    = 1'b1;
        tick();
        vec++; if (hs8 !== 1'b0) begin err++; $display("FAIL sync_early got %b want 0", hs8); end
        blank_in = 1'b0;
        hs_in    = 1'b0;
        vs_in    = 1'b1;
        tick();
        vec++; if ({r8, g8, b8} !== 24'h0 || {r2, g2, b2} !== 6'h0) begin err++; $display("FAIL blank_rgb got %h/%b want 000000/000000", {r8, g8, b8}, {r2, g2, b2}); end
        vec++; if ({hs8, vs8, ov8, hs2} !== 4'b1011) begin err++; $display("FAIL blank_hs got %b want 1011", {hs8, vs8, ov8, hs2}); end
        vs_in = 1'b0;
        tick();
        vec++; if ({r8, g8, b8} !== 24'hFFFFFF) begin err++; $display("FAIL unblank_rgb got %h want ffffff", {r8, g8, b8}); end
        vec++; if ({hs8, vs8} !== 2'b01) begin err++; $display("FAIL vs_pulse got %b want 01", {hs8, vs8}); end
        tick();
        vec++; if ({hs8, vs8} !== 2'b00) begin err++; $display("FAIL sync_end got %b want 00", {hs8, vs8}); end
    endtask

    task automatic test_rst_mid_load;
        int n;
        pal_reload = 1'b1;
        tick();
        pal_reload = 1'b0;
        repeat (8) tick();
        vec++; if (busy8 !== 1'b1) begin err++; $display("FAIL midload_busy got %b want 1", busy8); end
        rst = 1'b1;
        tick();
        vec++; if ({busy8, wr_ready8, r8, g8, b8} !== 26'h2000000) begin err++; $display("FAIL midload_rst got %h want 2000000", {busy8, wr_ready8, r8, g8, b8}); end
        rst = 1'b0;
        n = 0;
        while (busy8 && n < 40) begin
            tick();
            n++;
        end
        vec++; if (n !== 16) begin err++; $display("FAIL midload_len got %0d want 16", n); end
        pix_rgbi = 4'd6;
        tick();
        tick();
        vec++; if ({r8, g8, b8} !== 24'hAA5500) begin err++; $display("FAIL midload_idx6 got %h want aa5500", {r8, g8, b8}); end
        pix_rgbi = 4'd1;
        tick();
        tick();
        vec++; if ({r8, g8, b8} !== 24'h0000AA) begin err++; $display("FAIL midload_idx1 got %h want 0000aa", {r8, g8, b8}); end
`ifdef CGA_PAL_READBACK_EN
        rd_addr = 4'd6;
        tick();
        vec++; if (rd_data8 !== 24'hAA5500) begin err++; $display("FAIL readback8 got %h want aa5500", rd_data8); end
        vec++; if (rd_data2 !== 6'b10_01_00) begin err++; $display("FAIL readback2 got %b want 100100", rd_data2); end
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        pix_valid  = 1'b0;
        pix_rgbi   = 4'd0;
        blank_in   = 1'b0;
        hs_in      = 1'b0;
        vs_in      = 1'b0;
        wr_valid   = 1'b0;
        wr_addr    = 4'd0;
        wr_data2   = 6'd0;
        wr_data8   = 24'd0;
        pal_reload = 1'b0;
`ifdef CGA_PAL_READBACK_EN
        rd_addr    = 4'd0;
`endif
        test_reset();
        test_sweep();
        test_ch8();
        test_collision();
        test_reload();
        test_blank_sync();
        test_rst_mid_load();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
